divide_unit: RTL and testbench

Multi-cycle RV32M divide/remainder unit sitting directly downstream of the register file in the execute stage. It consumes the registered `rs1_data`/`rs2_data` operands and the destination index, runs a 32-step restoring division, and returns a 32-bit result with `rd` for write-back into the register file. The start/busy/done handshake lets the pipeline stall while a division is in flight.

---
 rtl/divide_unit_if.sv | 42 ++++
 rtl/divide_unit.sv | 223 ++++++++++++++++++++++
 tb/tb_divide_unit.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/divide_unit_if.sv
// ---------------------------------------------------------------------------
// divide_unit_if
// Request/response bundle between the execute stage and the divide unit.
//
// Signals
//   start     request strobe, sampled only while the unit is idle
//   flush     synchronous abort of the operation in flight
//   funct3    100 DIV, 101 DIVU, 110 REM, 111 REMU
//   rs1_data  dividend
//   rs2_data  divisor
//   rd_in     destination register of the request
//   busy      unit is not idle
//   done      single-cycle completion pulse
//   result    quotient or remainder, held until the next done
//   rd_out    destination register, held until the next done
//
// Modports
//   master  pipeline side, drives the request
//   slave   divide unit side, drives the response
// ---------------------------------------------------------------------------
interface divide_unit_if;
   logic        start;
   logic        flush;
   logic [2:0]  funct3;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [4:0]  rd_in;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic [4:0]  rd_out;

   modport master (
      output start, flush, funct3, rs1_data, rs2_data, rd_in,
      input  busy, done, result, rd_out
   );

   modport slave (
      input  start, flush, funct3, rs1_data, rs2_data, rd_in,
      output busy, done, result, rd_out
   );
endinterface

// File: rtl/divide_unit.sv
// ---------------------------------------------------------------------------
// divide_unit
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit. Operands are converted to
// magnitudes on accept, a 32-step restoring division runs MSB first, and
// the signs are applied in a final fix-up cycle. Divide-by-zero and signed
// overflow are resolved on the accept edge and skip straight to DONE.
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    divide_unit_if.slave: request (start/flush/funct3/rs1/rs2/rd_in)
//          and response (busy/done/result/rd_out)
// ---------------------------------------------------------------------------
module divide_unit (
   input  logic          clk,
   input  logic          rst_n,
   divide_unit_if.slave  bus
);

   // state | meaning
   // ------+------------------------------------------------------------
   // IDLE  | no operation in progress; start is sampled here only
   // CALC  | 32 restoring-division steps, cnt_q counts 0..31
   // FIX   | apply result signs, select quotient/remainder into result
   // DONE  | done pulse, result/rd_out valid; returns to IDLE
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        is_rem_q, is_rem_d;
   logic        sign1_q, sign1_d;
   logic        sign2_q, sign2_d;
   logic [4:0]  rd_q, rd_d;
   logic [31:0] dvsr_q, dvsr_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] result_q, result_d;
   logic [4:0]  rd_out_q, rd_out_d;

   logic        accept;
   logic        signed_op;
   logic        in_sign1;
   logic        in_sign2;
   logic [31:0] in_mag1;
   logic [31:0] in_mag2;
   logic        div_zero;
   logic        sgn_ovf;
   logic        special;
   logic [31:0] special_res;
   logic [32:0] rem_sh;
   logic [32:0] trial;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;

   // -----------------------------------------------------------------------
   // Request decode
   // -----------------------------------------------------------------------
   assign accept    = (state_q == ST_IDLE) && bus.start && !bus.flush && bus.funct3[2];
   assign signed_op = !bus.funct3[0];
   assign in_sign1  = signed_op && bus.rs1_data[31];
   assign in_sign2  = signed_op && bus.rs2_data[31];
   assign in_mag1   = in_sign1 ? (32'd0 - bus.rs1_data) : bus.rs1_data;
   assign in_mag2   = in_sign2 ? (32'd0 - bus.rs2_data) : bus.rs2_data;

   assign div_zero  = (bus.rs2_data == 32'd0);
   assign sgn_ovf   = signed_op && (bus.rs1_data == 32'h8000_0000)
                      && (bus.rs2_data == 32'hFFFF_FFFF);
   assign special   = div_zero || sgn_ovf;

   // Divide by zero: q = all ones, r = raw dividend. Overflow: q = INT_MIN, r = 0.
   always_comb begin
      special_res = 32'd0;
      if (bus.funct3[1]) begin
         special_res = div_zero ? bus.rs1_data : 32'd0;
      end else begin
         special_res = div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
      end
   end

   // -----------------------------------------------------------------------
   // Restoring step. The shifted remainder needs 33 bits because the
   // unsigned divisor can use all 32; trial[32] set means "does not fit".
   // -----------------------------------------------------------------------
   assign rem_sh  = {rem_q, quo_q[31]};
   assign trial   = rem_sh - {1'b0, dvsr_q};

   // Remainder follows the dividend's sign, quotient is negative on mixed signs.
   assign quo_fix = (sign1_q ^ sign2_q) ? (32'd0 - quo_q) : quo_q;
   assign rem_fix = sign1_q ? (32'd0 - rem_q) : rem_q;

   // -----------------------------------------------------------------------
   // FSM: state register
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // -----------------------------------------------------------------------
   // FSM: next state
   // -----------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = special ? ST_DONE : ST_CALC;
            end
         end
         ST_CALC: begin
            if (cnt_q == 5'd31) begin
               state_d = ST_FIX;
            end
         end
         ST_FIX:  state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (bus.flush) begin
         state_d = ST_IDLE;
      end
   end

   // -----------------------------------------------------------------------
   // FSM: outputs, decoded from state only
   // -----------------------------------------------------------------------
   always_comb begin
      bus.busy = (state_q != ST_IDLE);
      bus.done = (state_q == ST_DONE);
   end

   assign bus.result = result_q;
   assign bus.rd_out = rd_out_q;

   // -----------------------------------------------------------------------
   // Datapath next values. A flush freezes everything so result/rd_out keep
   // their last delivered values.
   // -----------------------------------------------------------------------
   always_comb begin
      cnt_d    = cnt_q;
      is_rem_d = is_rem_q;
      sign1_d  = sign1_q;
      sign2_d  = sign2_q;
      rd_d     = rd_q;
      dvsr_d   = dvsr_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      result_d = result_q;
      rd_out_d = rd_out_q;

      if (!bus.flush) begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  cnt_d    = 5'd0;
                  is_rem_d = bus.funct3[1];
                  sign1_d  = in_sign1;
                  sign2_d  = in_sign2;
                  rd_d     = bus.rd_in;
                  dvsr_d   = in_mag2;
                  rem_d    = 32'd0;
                  quo_d    = in_mag1;
                  if (special) begin
                     result_d = special_res;
                     rd_out_d = bus.rd_in;
                  end
               end
            end
            ST_CALC: begin
               cnt_d = cnt_q + 5'd1;
               if (!trial[32]) begin
                  rem_d = trial[31:0];
                  quo_d = {quo_q[30:0], 1'b1};
               end else begin
                  rem_d = rem_sh[31:0];
                  quo_d = {quo_q[30:0], 1'b0};
               end
            end
            ST_FIX: begin
               result_d = is_rem_q ? rem_fix : quo_fix;
               rd_out_d = rd_q;
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= 5'd0;
         is_rem_q <= 1'b0;
         sign1_q  <= 1'b0;
         sign2_q  <= 1'b0;
         rd_q     <= 5'd0;
         dvsr_q   <= 32'd0;
         rem_q    <= 32'd0;
         quo_q    <= 32'd0;
         result_q <= 32'd0;
         rd_out_q <= 5'd0;
      end else begin
         cnt_q    <= cnt_d;
         is_rem_q <= is_rem_d;
         sign1_q  <= sign1_d;
         sign2_q  <= sign2_d;
         rd_q     <= rd_d;
         dvsr_q   <= dvsr_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         result_q <= result_d;
         rd_out_q <= rd_out_d;
      end
   end

endmodule

// File: tb/tb_divide_unit.sv
// ---------------------------------------------------------------------------
// tb_divide_unit
// Directed and randomized checks of divide_unit against an arithmetic
// reference model (SV division operators plus the RISC-V special cases).
// ---------------------------------------------------------------------------
module tb_divide_unit;

   localparam logic [2:0] F_DIV  = 3'b100;
   localparam logic [2:0] F_DIVU = 3'b101;
   localparam logic [2:0] F_REM  = 3'b110;
   localparam logic [2:0] F_REMU = 3'b111;

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   always #5 clk = ~clk;

   divide_unit_if bus ();

   divide_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int          n_checks = 0;
   int          n_fails  = 0;
   logic [31:0] last_res = 32'd0;
   logic [4:0]  last_rd  = 5'd0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
      logic [31:0] q;
      logic [31:0] r;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = 32'd0;
      end else if (!f3[0]) begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end else begin
         q = a / b;
         r = a % b;
      end
      return f3[1] ? r : q;
   endfunction

   function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
      if (b == 32'd0) return 1;
      if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 34;
   endfunction

   // Watches n cycles and expects the unit to stay idle with no done pulse.
   task automatic idle_watch(input int n, input string tag);
      int d = 0;
      int b = 0;
      repeat (n) begin
         @(negedge clk);
         if (bus.done !== 1'b0) d++;
         if (bus.busy !== 1'b0) b++;
      end
      chk({tag, "_no_done"}, d, 0);
      chk({tag, "_no_busy"}, b, 0);
   endtask

   // Issues one request; with hold=1, start stays high through busy and DONE.
   task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit hold, input string tag);
      int k;
      int ndone;
      logic [31:0] exp;
      exp = ref_result(f3, a, b);
      @(negedge clk);
      chk({tag, "_idle_before"}, bus.busy, 1'b0);
      bus.funct3   = f3;
      bus.rs1_data = a;
      bus.rs2_data = b;
      bus.rd_in    = rd;
      bus.start    = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) bus.start = 1'b0;
      k = 0;
      ndone = 0;
      while (k < 60) begin
         @(negedge clk);
         k++;
         if (k == 1) chk({tag, "_busy_rise"}, bus.busy, 1'b1);
         if (bus.done === 1'b1) begin
            ndone++;
            break;
         end
      end
      chk({tag, "_latency"}, k, ref_latency(f3, a, b));
      chk({tag, "_result"}, bus.result, exp);
      chk({tag, "_rd_out"}, bus.rd_out, rd);
      if (ndone == 1) begin
         last_res = exp;
         last_rd  = rd;
      end
      if (hold) begin
         @(negedge clk);
         chk({tag, "_busy_fall"}, bus.busy, 1'b0);
         bus.start = 1'b0;
         idle_watch(40, {tag, "_hold"});
      end
   endtask

   initial begin
      bus.start    = 1'b0;
      bus.flush    = 1'b0;
      bus.funct3   = 3'b000;
      bus.rs1_data = 32'd0;
      bus.rs2_data = 32'd0;
      bus.rd_in    = 5'd0;

      #2 rst_n = 1'b0;
      #1;
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_result", bus.result, 32'd0);
      chk("rst_rd_out", bus.rd_out, 5'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Directed arithmetic cases
      do_op(F_DIVU, 32'd100, 32'd7, 5'd5, 1'b0, "divu_100_7");
      do_op(F_REMU, 32'd100, 32'd7, 5'd5, 1'b0, "remu_100_7");
      do_op(F_DIV,  32'hFFFF_FFF9, 32'd2, 5'd9, 1'b0, "div_m7_2");
      do_op(F_REM,  32'hFFFF_FFF9, 32'd2, 5'd10, 1'b0, "rem_m7_2");
      do_op(F_REM,  32'd7, 32'hFFFF_FFFE, 5'd11, 1'b0, "rem_7_m2");
      do_op(F_DIV,  32'h0000_1234, 32'd0, 5'd12, 1'b0, "div_by0");
      do_op(F_REMU, 32'h0000_1234, 32'd0, 5'd13, 1'b0, "remu_by0");
      do_op(F_REM,  32'hFFFF_FFF0, 32'd0, 5'd14, 1'b0, "rem_neg_by0");
      do_op(F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 1'b0, "div_ovf");
      do_op(F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 1'b0, "rem_ovf");
      do_op(F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 1'b0, "divu_no_ovf");
      do_op(F_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'd18, 1'b0, "divu_big");

      // Start held through busy and DONE: exactly one completion
      do_op(F_DIV, 32'd1000, 32'hFFFF_FFFD, 5'd19, 1'b1, "hold_start");
      do_op(F_REMU, 32'd5, 32'd0, 5'd20, 1'b1, "hold_start_sp");

      // Non-M funct3 is ignored
      @(negedge clk);
      bus.funct3 = 3'b000;
      bus.rs1_data = 32'd50;
      bus.rs2_data = 32'd5;
      bus.start = 1'b1;
      repeat (3) @(posedge clk);
      #1 bus.start = 1'b0;
      chk("ignore_f3_busy", bus.busy, 1'b0);
      idle_watch(5, "ignore_f3");

      // Back-to-back: each do_op issues on the first IDLE cycle after done
      do_op(F_DIVU, 32'd81, 32'd9, 5'd21, 1'b0, "b2b_a");
      do_op(F_REMU, 32'd81, 32'd10, 5'd22, 1'b0, "b2b_b");

      // Flush in the middle of CALC
      @(negedge clk);
      bus.funct3 = F_DIV;
      bus.rs1_data = 32'd1000;
      bus.rs2_data = 32'd3;
      bus.rd_in = 5'd30;
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (10) @(negedge clk);
      bus.flush = 1'b1;
      @(posedge clk);
      #1 bus.flush = 1'b0;
      @(negedge clk);
      chk("flush_busy", bus.busy, 1'b0);
      idle_watch(40, "flush");
      chk("flush_result_kept", bus.result, last_res);
      chk("flush_rd_kept", bus.rd_out, last_rd);

      // Reset in the middle of CALC
      @(negedge clk);
      bus.funct3 = F_DIVU;
      bus.rs1_data = 32'd999;
      bus.rs2_data = 32'd4;
      bus.rd_in = 5'd31;
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", bus.busy, 1'b0);
      chk("midrst_done", bus.done, 1'b0);
      chk("midrst_result", bus.result, 32'd0);
      chk("midrst_rd_out", bus.rd_out, 5'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle_watch(40, "midrst");

      // Randomized operations with biased operand picks
      for (int i = 0; i < 150; i++) begin
         logic [31:0] ops [2];
         logic [2:0]  f3;
         for (int j = 0; j < 2; j++) begin
            case ($urandom_range(0, 7))
               0: ops[j] = 32'd0;
               1: ops[j] = 32'hFFFF_FFFF;
               2: ops[j] = 32'h8000_0000;
               3: ops[j] = 32'($urandom_range(0, 20));
               4: ops[j] = 32'd0 - 32'($urandom_range(1, 20));
               default: ops[j] = $urandom;
            endcase
         end
         f3 = {1'b1, 2'($urandom_range(0, 3))};
         do_op(f3, ops[0], ops[1], 5'($urandom_range(0, 31)), 1'b0, "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
